// File: rtl/bit_serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request side. The slave (the subtractor) drives the result side.
interface bit_serial_subtractor_if #(
   parameter int N = 8
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] diff;
   logic         borrow_out;
   logic         overflow;
   logic         busy;
   logic         done;

   modport master (
      output start, a, b,
      input  diff, borrow_out, overflow, busy, done
   );

   modport slave (
      input  start, a, b,
      output diff, borrow_out, overflow, busy, done
   );
endinterface

// File: rtl/bit_serial_subtractor.sv
// LSB-first bit-serial subtractor: diff = a - b mod 2^N, one bit per clock.
// Operands are captured when start is accepted in IDLE or DONE.
// The result, final borrow and two's-complement overflow all update together on the last bit.
// They hold their values until the next completion.
module bit_serial_subtractor #(
   parameter int N = 8
) (
   input logic                     clk,
   input logic                     rst,
   bit_serial_subtractor_if.slave  bus
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic            load_s;
   logic            shift_s;
   logic            last_s;

   logic [CW-1:0]   cnt_r;
   logic [N-1:0]    a_sh_r;
   logic [N-1:0]    b_sh_r;
   logic [N-2:0]    part_r;
   logic [N-1:0]    part_nxt_s;
   logic            borrow_r;
   logic            a_msb_r;
   logic            b_msb_r;

   logic            a_bit_s;
   logic            b_bit_s;
   logic            d_s;
   logic            bout_s;

   logic [N-1:0]    diff_r;
   logic            borrow_out_r;
   logic            overflow_r;
   logic            busy_r;
   logic            done_r;

   assign last_s = (cnt_r == CW'(N - 1));

   // One full-subtractor step on the current LSBs, and the partial result after this bit enters at the MSB end.
   always_comb begin
      a_bit_s    = a_sh_r[0];
      b_bit_s    = b_sh_r[0];
      d_s        = a_bit_s ^ b_bit_s ^ borrow_r;
      bout_s     = (~a_bit_s & b_bit_s) | (~(a_bit_s ^ b_bit_s) & borrow_r);
      part_nxt_s = {d_s, part_r};
   end

   // Next-state logic: accept start in IDLE or DONE, and leave SHIFT on the last bit.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      shift_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_nxt_s = SHIFT;
               load_s      = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            shift_s = 1'b1;
            if (last_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         DONE: begin
            if (bus.start) begin
               state_nxt_s = SHIFT;
               load_s      = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // busy and done come from the next state, so each is a flop and never high together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s == SHIFT);
         done_r <= (state_nxt_s == DONE);
      end
   end

   // Operand capture and serial datapath. The result registers load only on the last bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r        <= '0;
         a_sh_r       <= '0;
         b_sh_r       <= '0;
         part_r       <= '0;
         borrow_r     <= 1'b0;
         a_msb_r      <= 1'b0;
         b_msb_r      <= 1'b0;
         diff_r       <= '0;
         borrow_out_r <= 1'b0;
         overflow_r   <= 1'b0;
      end else if (load_s) begin
         cnt_r    <= '0;
         a_sh_r   <= bus.a;
         b_sh_r   <= bus.b;
         part_r   <= '0;
         borrow_r <= 1'b0;
         a_msb_r  <= bus.a[N-1];
         b_msb_r  <= bus.b[N-1];
      end else if (shift_s) begin
         cnt_r    <= cnt_r + CW'(1);
         a_sh_r   <= {1'b0, a_sh_r[N-1:1]};
         b_sh_r   <= {1'b0, b_sh_r[N-1:1]};
         part_r   <= part_nxt_s[N-1:1];
         borrow_r <= bout_s;
         if (last_s) begin
            diff_r       <= part_nxt_s;
            borrow_out_r <= bout_s;
            // Signs of the operands differ and the result sign differs from the minuend.
            overflow_r   <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ d_s);
         end
      end
   end

   assign bus.diff       = diff_r;
   assign bus.borrow_out = borrow_out_r;
   assign bus.overflow   = overflow_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Scoreboard bench for bit_serial_subtractor at N=8 and N=5.
// Expected results are queued when a request is accepted.
// They are popped and compared when done pulses.
module tb_bit_serial_subtractor;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bit_serial_subtractor_if #(.N(8)) if8 ();
   bit_serial_subtractor_if #(.N(5)) if5 ();

   bit_serial_subtractor #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
   bit_serial_subtractor #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));

   // Free-running clock.
   always #5 clk = ~clk;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [9:0] exp8_q[$];
   logic [9:0] exp5_q[$];
   logic [9:0] e8;
   logic [9:0] e5;
   logic       prev_done8  = 1'b0;
   logic       prev_done5  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: {overflow, borrow, diff[7:0]} for a w-bit subtraction, using signed range for overflow.
   function automatic logic [9:0] ref_sub(input int w, input int a, input int b);
      int         half;
      int         sa;
      int         sb;
      int         sd;
      logic       ovf;
      logic       brw;
      logic [7:0] d;
      half = 1 << (w - 1);
      sa   = (a >= half) ? a - (1 << w) : a;
      sb   = (b >= half) ? b - (1 << w) : b;
      sd   = sa - sb;
      ovf  = (sd > half - 1) || (sd < -half);
      brw  = (a < b);
      d    = 8'((a - b) & ((1 << w) - 1));
      return {ovf, brw, d};
   endfunction

   // Result scoreboard and done-pulse / busy-done exclusivity monitor.
   always @(negedge clk) begin
      if (if8.done === 1'b1) begin
         if (exp8_q.size() == 0) begin
            check("sb8_unexpected_done", 32'd1, 32'd0);
         end else begin
            e8 = exp8_q.pop_front();
            check("diff8", 32'(if8.diff), 32'(e8[7:0]));
            check("borrow8", 32'(if8.borrow_out), 32'(e8[8]));
            check("ovf8", 32'(if8.overflow), 32'(e8[9]));
            check("busy_done8", 32'(if8.busy), 32'd0);
         end
      end
      if (prev_done8 === 1'b1) check("done_width8", 32'(if8.done), 32'd0);
      prev_done8 = if8.done;

      if (if5.done === 1'b1) begin
         if (exp5_q.size() == 0) begin
            check("sb5_unexpected_done", 32'd1, 32'd0);
         end else begin
            e5 = exp5_q.pop_front();
            check("diff5", 32'(if5.diff), 32'(e5[7:0]));
            check("borrow5", 32'(if5.borrow_out), 32'(e5[8]));
            check("ovf5", 32'(if5.overflow), 32'(e5[9]));
            check("busy_done5", 32'(if5.busy), 32'd0);
         end
      end
      if (prev_done5 === 1'b1) check("done_width5", 32'(if5.done), 32'd0);
      prev_done5 = if5.done;
   end

   task automatic start8(input logic [7:0] a, input logic [7:0] b);
      if8.a     = a;
      if8.b     = b;
      if8.start = 1'b1;
      exp8_q.push_back(ref_sub(8, int'(a), int'(b)));
      @(posedge clk);
      #1;
      if8.start = 1'b0;
      check("accept8", 32'(if8.busy), 32'd1);
      check("nodone8", 32'(if8.done), 32'd0);
   endtask

   task automatic start5(input logic [4:0] a, input logic [4:0] b);
      if5.a     = a;
      if5.b     = b;
      if5.start = 1'b1;
      exp5_q.push_back(ref_sub(5, int'(a), int'(b)));
      @(posedge clk);
      #1;
      if5.start = 1'b0;
      check("accept5", 32'(if5.busy), 32'd1);
   endtask

   task automatic wait_done8(output int lat);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         lat = i + 1;
         if (if8.done === 1'b1) break;
      end
   endtask

   task automatic wait_done5(output int lat);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         lat = i + 1;
         if (if5.done === 1'b1) break;
      end
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b);
      int lat;
      start8(a, b);
      wait_done8(lat);
      check("latency8", 32'(lat), 32'd8);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Directed cases followed by the randomized sweep.
   initial begin
      int lat;
      logic [9:0] held;
      if8.start = 1'b0; if8.a = 8'h00; if8.b = 8'h00;
      if5.start = 1'b0; if5.a = 5'h00; if5.b = 5'h00;
      repeat (2) @(negedge clk);
      check("rst_diff8", 32'(if8.diff), 32'd0);
      check("rst_borrow8", 32'(if8.borrow_out), 32'd0);
      check("rst_ovf8", 32'(if8.overflow), 32'd0);
      check("rst_busy8", 32'(if8.busy), 32'd0);
      check("rst_done8", 32'(if8.done), 32'd0);
      check("rst_diff5", 32'(if5.diff), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic, borrow, zero and overflow cases.
      op8(8'h45, 8'h2A);
      op8(8'h2A, 8'h45);
      op8(8'h00, 8'h00);
      op8(8'h80, 8'h01);
      op8(8'h7F, 8'hFF);

      // A start while busy is ignored; a start held in the DONE cycle runs back-to-back.
      start8(8'h10, 8'h01);
      repeat (2) @(posedge clk);
      #1;
      if8.a = 8'hFF; if8.b = 8'hFF; if8.start = 1'b1;
      @(posedge clk);
      #1;
      if8.start = 1'b0;
      check("ignored_busy8", 32'(if8.busy), 32'd1);
      wait_done8(lat);
      check("latency_ign8", 32'(lat), 32'd5);
      start8(8'h05, 8'h07);
      wait_done8(lat);
      check("latency_b2b8", 32'(lat), 32'd8);
      held = ref_sub(8, 5, 7);
      repeat (3) begin @(posedge clk); #1; end
      check("idle_hold_diff8", 32'(if8.diff), 32'(held[7:0]));
      check("idle_hold_borrow8", 32'(if8.borrow_out), 32'(held[8]));

      // An asynchronous reset in mid-operation clears outputs immediately.
      start8(8'h45, 8'h2A);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_diff8", 32'(if8.diff), 32'd0);
      check("abort_borrow8", 32'(if8.borrow_out), 32'd0);
      check("abort_ovf8", 32'(if8.overflow), 32'd0);
      check("abort_busy8", 32'(if8.busy), 32'd0);
      check("abort_done8", 32'(if8.done), 32'd0);
      exp8_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      op8(8'h03, 8'h01);

      // Randomized sweep with random idle gaps or back-to-back starts.
      for (int i = 0; i < 1000; i++) begin
         op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
      end
      for (int i = 0; i < 1000; i++) begin
         start5(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         wait_done5(lat);
         check("latency5", 32'(lat), 32'd5);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("sb8_leftover", 32'(exp8_q.size()), 32'd0);
      check("sb5_leftover", 32'(exp5_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
